// File: rtl/render_program_sequencer_pkg.sv
// Shared types for the render programming path: default widths, sequencer
// states and the buffered write record.
package render_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_REG_W  = 12;
    localparam int DEF_DATA_W = 12;

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT_FRAME,
        S_PROGRAM,
        S_RELEASE
    } seq_state_e;

    // One shape-register write; 35 bits with the default widths.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] shape;
        logic [DEF_REG_W-1:0]  reg_addr;
        logic [DEF_DATA_W-1:0] data;
    } write_rec_t;

endpackage

// File: rtl/render_program_sequencer_if.sv
// Programming stream, renderer handshake and register-file write bus of the
// render program sequencer. The sequencer takes the slave side.
interface render_program_sequencer_if
    import render_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              prog_valid;
    logic              prog_ready;
    logic [ADDR_W-1:0] prog_shape;
    logic [REG_W-1:0]  prog_reg;
    logic [DATA_W-1:0] prog_data;
    logic              resume;
    logic              frame_done;
    logic              render_halt;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_shape;
    logic [REG_W-1:0]  wr_reg;
    logic [DATA_W-1:0] wr_data;
    logic              busy;

    modport master (
        output prog_valid, prog_shape, prog_reg, prog_data, resume, frame_done,
        input  prog_ready, render_halt, wr_en, wr_shape, wr_reg, wr_data, busy
    );

    modport slave (
        input  prog_valid, prog_shape, prog_reg, prog_data, resume, frame_done,
        output prog_ready, render_halt, wr_en, wr_shape, wr_reg, wr_data, busy
    );
endinterface

// File: rtl/render_program_sequencer_fifo.sv
// Synchronous write-record FIFO. DEPTH must be a power of two (>= 2) so the
// pointers wrap naturally; callers never push when full nor pop when empty.
module prog_write_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 35
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; an entry is only read after it was written,
    // and leaving it out keeps the array in plain RAM cells.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
endmodule

// File: rtl/render_program_sequencer.sv
// Buffers shape-register writes and commits them only while the renderer is
// halted at a frame boundary, so no frame ever sees a half-updated table.
module render_program_sequencer
    import render_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int REG_W      = DEF_REG_W,
    parameter int DATA_W     = DEF_DATA_W
) (
    input logic                       clk,
    input logic                       rst,
    render_program_sequencer_if.slave bus
);
    localparam int REC_W = ADDR_W + REG_W + DATA_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    seq_state_e        state_q;
    logic              resume_pending_q;
    logic              render_halt_q;
    logic              busy_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_shape_q;
    logic [REG_W-1:0]  wr_reg_q;
    logic [DATA_W-1:0] wr_data_q;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [REC_W-1:0]  push_rec;
    logic [REC_W-1:0]  head_rec;
    logic              resume_seen;
    logic              release_ok;

    assign fifo_push   = bus.prog_valid && !fifo_full;
    assign push_rec    = {bus.prog_shape, bus.prog_reg, bus.prog_data};
    assign fifo_pop    = (state_q == S_PROGRAM) && (fifo_count != '0);
    assign resume_seen = resume_pending_q || bus.resume;
    // A push landing on the exit check keeps the session open so it commits now.
    assign release_ok  = (state_q == S_PROGRAM) && fifo_empty && !fifo_pop
                         && resume_seen && !fifo_push;

    prog_write_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (push_rec),
        .pop_i       (fifo_pop),
        .pop_data_o  (head_rec),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_RUN;
            resume_pending_q <= 1'b0;
            render_halt_q    <= 1'b0;
            busy_q           <= 1'b0;
            wr_en_q          <= 1'b0;
            wr_shape_q       <= '0;
            wr_reg_q         <= '0;
            wr_data_q        <= '0;
        end else begin
            wr_en_q <= fifo_pop;
            if (fifo_pop) {wr_shape_q, wr_reg_q, wr_data_q} <= head_rec;

            case (state_q)
                S_RUN: begin
                    if (!fifo_empty) begin
                        state_q <= S_WAIT_FRAME;
                        busy_q  <= 1'b1;
                    end
                end
                S_WAIT_FRAME: begin
                    if (bus.resume) resume_pending_q <= 1'b1;
                    if (bus.frame_done) begin
                        state_q       <= S_PROGRAM;
                        render_halt_q <= 1'b1;
                    end
                end
                S_PROGRAM: begin
                    if (bus.resume) resume_pending_q <= 1'b1;
                    if (release_ok) state_q <= S_RELEASE;
                end
                S_RELEASE: begin
                    // One quiet cycle lets the final write land before restart.
                    state_q          <= S_RUN;
                    resume_pending_q <= 1'b0;
                    render_halt_q    <= 1'b0;
                    busy_q           <= 1'b0;
                end
                default: begin
                    state_q          <= S_RUN;
                    resume_pending_q <= 1'b0;
                    render_halt_q    <= 1'b0;
                    busy_q           <= 1'b0;
                end
            endcase
        end
    end

    assign bus.prog_ready  = !fifo_full;
    assign bus.render_halt = render_halt_q;
    assign bus.busy        = busy_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_shape    = wr_shape_q;
    assign bus.wr_reg      = wr_reg_q;
    assign bus.wr_data     = wr_data_q;
endmodule

// File: tb/tb_render_program_sequencer.sv
// Bench for render_program_sequencer: cycle table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_render_program_sequencer;
    import render_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    always #5 clk = ~clk;

    render_program_sequencer_if bus_if ();

    render_program_sequencer #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        logic                  rst;
        logic                  valid;
        logic [DEF_ADDR_W-1:0] shape;
        logic [DEF_REG_W-1:0]  reg_addr;
        logic [DEF_DATA_W-1:0] data;
        logic                  resume;
        logic                  frame_done;
        logic                  exp_ready;
        logic                  exp_halt;
        logic                  exp_busy;
        logic                  exp_wr_en;
        logic                  chk_bus;
        write_rec_t            exp_wr;
    } vec_t;

    vec_t       vecs[$];
    write_rec_t wr_log[$];
    write_rec_t exp_q[$];
    logic       prev_halt = 1'b0;
    logic       prev_wr_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_compared++;
        n_mismatched++;
        $display("FAIL %s: cycle budget expired", name);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Record every committed write and watch the halt/write relationship.
    always begin
        @(posedge clk);
        #1;
        if (bus_if.wr_en === 1'b1) begin
            write_rec_t r;
            r.shape    = bus_if.wr_shape;
            r.reg_addr = bus_if.wr_reg;
            r.data     = bus_if.wr_data;
            wr_log.push_back(r);
            check("wr_en_while_halted", bus_if.render_halt, 1'b1);
        end
        if (prev_halt === 1'b1 && bus_if.render_halt === 1'b0)
            check("halt_fall_without_write", {prev_wr_en, bus_if.wr_en}, 2'b00);
        prev_halt  = bus_if.render_halt;
        prev_wr_en = bus_if.wr_en;
    end

    function automatic void add_vec(
        input logic r, input logic v, input logic [10:0] s, input logic [11:0] ra,
        input logic [11:0] d, input logic res, input logic fd,
        input logic e_rdy, input logic e_halt, input logic e_busy, input logic e_wr,
        input logic chk, input logic [10:0] es, input logic [11:0] er, input logic [11:0] ed);
        vec_t x;
        x.rst = r;  x.valid = v;  x.shape = s;  x.reg_addr = ra;  x.data = d;
        x.resume = res;  x.frame_done = fd;
        x.exp_ready = e_rdy;  x.exp_halt = e_halt;  x.exp_busy = e_busy;
        x.exp_wr_en = e_wr;  x.chk_bus = chk;
        x.exp_wr.shape = es;  x.exp_wr.reg_addr = er;  x.exp_wr.data = ed;
        vecs.push_back(x);
    endfunction

    task automatic clear_inputs();
        bus_if.prog_valid = 1'b0;
        bus_if.prog_shape = '0;
        bus_if.prog_reg   = '0;
        bus_if.prog_data  = '0;
        bus_if.resume     = 1'b0;
        bus_if.frame_done = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wr_log.delete();
    endtask

    task automatic push_word(input logic [10:0] s, input logic [11:0] r, input logic [11:0] d);
        int budget = 100;
        bus_if.prog_valid = 1'b1;
        bus_if.prog_shape = s;
        bus_if.prog_reg   = r;
        bus_if.prog_data  = d;
        while (bus_if.prog_ready !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) timeout("push_wait");
        tick();
        bus_if.prog_valid = 1'b0;
    endtask

    task automatic pulse_frame_done();
        bus_if.frame_done = 1'b1;
        tick();
        bus_if.frame_done = 1'b0;
    endtask

    task automatic pulse_resume();
        bus_if.resume = 1'b1;
        tick();
        bus_if.resume = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int budget = 200;
        while (bus_if.busy !== 1'b0 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) timeout(name);
    endtask

    initial begin
        int accepted;
        int budget;
        logic take;
        write_rec_t cur;

        clear_inputs();
        @(negedge clk);

        // ---- cycle table: reset, idle frame_done, single write, resume ----
        //       rst v  shape  reg     data    res fd  rdy hlt bsy wr chk shape reg     data
        add_vec(1, 0, 0,     0,      0,      0,  0,  1,  0,  0,  0, 1,  0,    0,      0);
        add_vec(1, 0, 0,     0,      0,      0,  0,  1,  0,  0,  0, 1,  0,    0,      0);
        add_vec(0, 0, 0,     0,      0,      0,  1,  1,  0,  0,  0, 1,  0,    0,      0);
        add_vec(0, 0, 0,     0,      0,      0,  0,  1,  0,  0,  0, 0,  0,    0,      0);
        add_vec(0, 1, 5,     12'h012, 12'hABC, 0, 0,  1,  0,  0,  0, 0,  0,    0,      0);
        add_vec(0, 0, 0,     0,      0,      0,  0,  1,  0,  1,  0, 0,  0,    0,      0);
        add_vec(0, 0, 0,     0,      0,      0,  0,  1,  0,  1,  0, 0,  0,    0,      0);
        add_vec(0, 0, 0,     0,      0,      0,  0,  1,  0,  1,  0, 0,  0,    0,      0);
        add_vec(0, 0, 0,     0,      0,      0,  1,  1,  1,  1,  0, 0,  0,    0,      0);
        add_vec(0, 0, 0,     0,      0,      0,  0,  1,  1,  1,  1, 1,  5,    12'h012, 12'hABC);
        add_vec(0, 0, 0,     0,      0,      0,  0,  1,  1,  1,  0, 0,  0,    0,      0);
        add_vec(0, 0, 0,     0,      0,      1,  0,  1,  1,  1,  0, 0,  0,    0,      0);
        add_vec(0, 0, 0,     0,      0,      0,  0,  1,  0,  0,  0, 0,  0,    0,      0);
        add_vec(0, 0, 0,     0,      0,      0,  1,  1,  0,  0,  0, 0,  0,    0,      0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst               = vecs[i].rst;
            bus_if.prog_valid = vecs[i].valid;
            bus_if.prog_shape = vecs[i].shape;
            bus_if.prog_reg   = vecs[i].reg_addr;
            bus_if.prog_data  = vecs[i].data;
            bus_if.resume     = vecs[i].resume;
            bus_if.frame_done = vecs[i].frame_done;
            tick();
            check($sformatf("vec%0d_ready", i), bus_if.prog_ready,  vecs[i].exp_ready);
            check($sformatf("vec%0d_halt", i),  bus_if.render_halt, vecs[i].exp_halt);
            check($sformatf("vec%0d_busy", i),  bus_if.busy,        vecs[i].exp_busy);
            check($sformatf("vec%0d_wr_en", i), bus_if.wr_en,       vecs[i].exp_wr_en);
            if (vecs[i].chk_bus)
                check($sformatf("vec%0d_wr_bus", i),
                      {bus_if.wr_shape, bus_if.wr_reg, bus_if.wr_data}, vecs[i].exp_wr);
        end
        clear_inputs();

        // ---- back-pressure: 10 writes into an 8-deep buffer ----
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            push_word(11'(i), 12'(i), 12'(i));
            check($sformatf("bp_ready_after_%0d", i), bus_if.prog_ready, (i < DEPTH));
        end
        bus_if.prog_valid = 1'b1;
        bus_if.prog_shape = 11'd9;
        bus_if.prog_reg   = 12'd9;
        bus_if.prog_data  = 12'd9;
        pulse_frame_done();
        check("bp_halt_on_frame", bus_if.render_halt, 1'b1);
        push_word(11'd9, 12'd9, 12'd9);
        push_word(11'd10, 12'd10, 12'd10);
        pulse_resume();
        wait_idle("bp_idle");
        check("bp_write_count", wr_log.size(), 10);
        for (int i = 0; i < 10 && i < wr_log.size(); i++)
            check($sformatf("bp_write%0d", i), wr_log[i], {11'(i + 1), 12'(i + 1), 12'(i + 1)});
        check("bp_halt_released", bus_if.render_halt, 1'b0);

        // ---- resume on the first PROGRAM cycle, 6 entries queued ----
        do_reset();
        for (int i = 0; i < 6; i++) push_word(11'(16 + i), 12'h100 + 12'(i), 12'h200 + 12'(i));
        tick();
        tick();
        pulse_frame_done();
        check("rbd_halt_first_program", bus_if.render_halt, 1'b1);
        pulse_resume();
        wait_idle("rbd_idle");
        check("rbd_write_count", wr_log.size(), 6);
        for (int i = 0; i < 6 && i < wr_log.size(); i++)
            check($sformatf("rbd_write%0d", i), wr_log[i],
                  {11'(16 + i), 12'h100 + 12'(i), 12'h200 + 12'(i)});
        check("rbd_halt_released", bus_if.render_halt, 1'b0);

        // ---- frame_done and resume together in WAIT_FRAME ----
        do_reset();
        push_word(11'h7FF, 12'h777, 12'h777);
        tick();
        tick();
        bus_if.frame_done = 1'b1;
        bus_if.resume     = 1'b1;
        tick();
        clear_inputs();
        check("sim_halt", bus_if.render_halt, 1'b1);
        wait_idle("sim_idle");
        check("sim_write_count", wr_log.size(), 1);
        if (wr_log.size() > 0) check("sim_write", wr_log[0], {11'h7FF, 12'h777, 12'h777});
        // The old resume must not release the next session on its own.
        push_word(11'h001, 12'h002, 12'h778);
        tick();
        tick();
        pulse_frame_done();
        for (int i = 0; i < 6; i++) tick();
        check("sim_pending_cleared_halt", bus_if.render_halt, 1'b1);
        check("sim_second_write_count", wr_log.size(), 2);
        pulse_resume();
        wait_idle("sim_second_idle");
        check("sim_second_released", bus_if.render_halt, 1'b0);

        // ---- reset while 3 entries wait in PROGRAM ----
        do_reset();
        for (int i = 0; i < 3; i++) push_word(11'(i), 12'(i), 12'h300 + 12'(i));
        tick();
        tick();
        pulse_frame_done();
        check("rst_mid_halt_before", bus_if.render_halt, 1'b1);
        rst = 1'b1;
        tick();
        check("rst_mid_wr_en", bus_if.wr_en, 1'b0);
        check("rst_mid_halt", bus_if.render_halt, 1'b0);
        check("rst_mid_busy", bus_if.busy, 1'b0);
        check("rst_mid_ready", bus_if.prog_ready, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("rst_mid_no_writes", wr_log.size(), 0);
        check("rst_mid_stays_run", bus_if.busy, 1'b0);

        // ---- randomized traffic against an occupancy/order model ----
        do_reset();
        exp_q.delete();
        accepted = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (bus_if.prog_valid !== 1'b1) begin
                cur.shape    = DEF_ADDR_W'($urandom);
                cur.reg_addr = DEF_REG_W'($urandom);
                cur.data     = DEF_DATA_W'($urandom);
                bus_if.prog_valid = ($urandom_range(0, 3) != 0);
                bus_if.prog_shape = cur.shape;
                bus_if.prog_reg   = cur.reg_addr;
                bus_if.prog_data  = cur.data;
            end
            bus_if.frame_done = ($urandom_range(0, 15) == 0);
            bus_if.resume     = ($urandom_range(0, 11) == 0);
            check("rnd_ready", bus_if.prog_ready, (accepted - wr_log.size()) < DEPTH);
            take = bus_if.prog_valid && bus_if.prog_ready;
            if (take) begin
                exp_q.push_back(cur);
                accepted++;
            end
            tick();
            if (take) bus_if.prog_valid = 1'b0;
        end
        bus_if.prog_valid = 1'b0;
        budget = 400;
        while ((bus_if.busy !== 1'b0 || wr_log.size() != accepted) && budget > 0) begin
            bus_if.frame_done = 1'b1;
            bus_if.resume     = 1'b1;
            tick();
            budget--;
        end
        clear_inputs();
        if (budget == 0) timeout("rnd_drain");
        check("rnd_write_count", wr_log.size(), accepted);
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
            check($sformatf("rnd_write%0d", i), wr_log[i], exp_q[i]);
        check("rnd_final_halt", bus_if.render_halt, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
